// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
//   Free-running ultrasonic range finder front end. Fires a trigger pulse,
//   times the returned echo in clock cycles and classifies the width into a
//   2-bit obstacle zone for the motor mux select. Measurements repeat no
//   faster than once per PERIOD_CYCLES.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active high
//   echo          sensor echo pin (asynchronous, synchronized internally)
//   inputTrigger  sensor trigger pin
//   zone          00 stop, 01 near, 10 mid, 11 far / no echo
//   echo_cycles   last measured echo width, saturated at TIMEOUT_CYCLES
//   valid         one-cycle strobe when zone/echo_cycles/timeout update
//   timeout       last measurement timed out
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned PERIOD_CYCLES  = 3000000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned NEAR_TH        = 58000,
  parameter int unsigned MID_TH         = 145000,
  parameter int unsigned FAR_TH         = 290000,
  parameter int unsigned CNT_W          = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             echo,
  output logic             inputTrigger,
  output logic [1:0]       zone,
  output logic [CNT_W-1:0] echo_cycles,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] NEAR_C    = CNT_W'(NEAR_TH);
  localparam logic [CNT_W-1:0] MID_C     = CNT_W'(MID_TH);
  localparam logic [CNT_W-1:0] FAR_C     = CNT_W'(FAR_TH);

  localparam logic [1:0] Z_STOP = 2'b00;
  localparam logic [1:0] Z_NEAR = 2'b01;
  localparam logic [1:0] Z_MID  = 2'b10;
  localparam logic [1:0] Z_FAR  = 2'b11;

  typedef enum logic [2:0] {
    S_TRIG,
    S_ARM,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE,
    S_IDLE
  } state_e;

  // Published measurement result; updated only from DONE.
  typedef struct packed {
    logic [1:0]       zone;
    logic [CNT_W-1:0] cycles;
    logic             tmo;
  } res_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // trigger length / echo wait / echo width
  logic [CNT_W-1:0] per_q, per_d;     // cycles since the current trigger started
  logic             tmo_q, tmo_d;     // pending result timed out
  logic             echo_meta_q, echo_s_q;
  logic             trig_q, trig_d;
  logic             valid_q, valid_d;
  res_t             res_q, res_d;

  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + ONE;

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] w,
                                          input logic             to);
    logic [1:0] z;
    if (to)              z = Z_FAR;
    else if (w < NEAR_C) z = Z_STOP;
    else if (w < MID_C)  z = Z_NEAR;
    else if (w < FAR_C)  z = Z_MID;
    else                 z = Z_FAR;
    return z;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_TRIG: begin
        // echo is deliberately ignored while the trigger is high
        if (cnt_q >= TRIG_LAST) begin
          state_d = S_ARM;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ARM, S_WAIT_RISE: begin
        // One wait budget covers both states, so an echo stuck high after
        // the trigger still ends in a timeout.
        if (state_q == S_WAIT_RISE && echo_s_q) begin
          state_d = S_MEASURE;
          cnt_d   = ONE;
        end else if (cnt_inc >= TMO) begin
          state_d = S_DONE;
          cnt_d   = '0;            // no rise seen: report zero width
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (state_q == S_ARM && !echo_s_q) state_d = S_WAIT_RISE;
        end
      end
      S_MEASURE: begin
        if (cnt_q >= TMO) begin
          state_d = S_DONE;
          cnt_d   = TMO;
          tmo_d   = 1'b1;
        end else if (!echo_s_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TMO) begin
            state_d = S_DONE;
            tmo_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        // Skip IDLE when the period already ran out during the measurement.
        state_d = (per_q >= PER_LAST) ? S_TRIG : S_IDLE;
        cnt_d   = '0;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (per_q >= PER_LAST) state_d = S_TRIG;
      end
      default: begin
        state_d = S_TRIG;
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
    endcase
  end

  // Period counter restarts on every entry to TRIG and saturates so the
  // IDLE/DONE comparison stays true once the period has elapsed.
  always_comb begin
    per_d = per_q;
    if (state_d == S_TRIG && state_q != S_TRIG) per_d = '0;
    else if (per_q < PER_LAST)                  per_d = per_q + ONE;
  end

  // Registered outputs: the trigger follows the state one cycle late, which
  // makes its first high cycle land on the first edge after reset release.
  always_comb begin
    trig_d  = (state_q == S_TRIG);
    valid_d = (state_q == S_DONE);
    res_d   = res_q;
    if (state_q == S_DONE) begin
      res_d.zone   = classify(cnt_q, tmo_q);
      res_d.cycles = cnt_q;
      res_d.tmo    = tmo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_TRIG;
      cnt_q       <= '0;
      per_q       <= '0;
      tmo_q       <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      trig_q      <= 1'b0;
      valid_q     <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      tmo_q       <= tmo_d;
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      trig_q      <= trig_d;
      valid_q     <= valid_d;
      res_q       <= res_d;
    end
  end

  assign inputTrigger = trig_q;
  assign zone         = res_q.zone;
  assign echo_cycles  = res_q.cycles;
  assign timeout      = res_q.tmo;
  assign valid        = valid_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with short timing parameters.
module tb_ultrasonic_ranger;

  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          echo = 1'b0;
  logic          trig;
  logic [1:0]    zone;
  logic [CW-1:0] ecyc;
  logic          valid;
  logic          tmo;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int vcnt   = 0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .TRIG_CYCLES(4), .PERIOD_CYCLES(200), .TIMEOUT_CYCLES(100),
    .NEAR_TH(20), .MID_TH(40), .FAR_TH(80), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .echo(echo), .inputTrigger(trig),
    .zone(zone), .echo_cycles(ecyc), .valid(valid), .timeout(tmo)
  );

  // count every cycle that valid is high
  always @(negedge clk) if (valid === 1'b1) vcnt <= vcnt + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the trigger, then count its high cycles. Returns at
  // the first sample after the trigger has fallen.
  task automatic trig_pulse(input string tag, output int rise_cyc);
    int b;
    int hi;
    b = 0;
    while (trig !== 1'b1 && b < 400) begin tick(); b++; end
    chk({tag, "_trig_rise"}, trig, 1);
    rise_cyc = cyc;
    hi = 0;
    while (trig === 1'b1 && hi < 50) begin hi++; tick(); end
    chk({tag, "_trig_len"}, hi, 4);
  endtask

  task automatic wait_valid(input string tag, input int v0);
    int b;
    b = 0;
    while (vcnt == v0 && b < 300) begin tick(); b++; end
    tick(3);
    chk({tag, "_valid_pulses"}, vcnt - v0, 1);
  endtask

  // Echo of 'width' cycles starting 10 cycles after the trigger fell.
  task automatic meas(input string tag, input int width, input int exp_cyc,
                      input logic [1:0] exp_zone, input logic exp_to);
    int v0;
    v0 = vcnt;
    tick(10);
    echo = 1'b1;
    tick(width);
    echo = 1'b0;
    wait_valid(tag, v0);
    chk({tag, "_cycles"}, ecyc, exp_cyc);
    chk({tag, "_zone"}, zone, exp_zone);
    chk({tag, "_timeout"}, tmo, exp_to);
  endtask

  initial begin
    int t0, t1, v0, n;
    int         sw_w [6];
    logic [1:0] sw_z [6];
    sw_w = '{19, 20, 39, 40, 79, 80};
    sw_z = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};

    // reset state
    tick(3);
    chk("rst_trig", trig, 0);
    chk("rst_zone", zone, 0);
    chk("rst_cycles", ecyc, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", tmo, 0);

    // first trigger on the first edge after release
    rst = 1'b0;
    tick(1);
    chk("trig_first_edge", trig, 1);
    trig_pulse("first", t0);
    chk("pre_result_zone", zone, 0);
    chk("pre_result_valid_cnt", vcnt, 0);

    meas("w30", 30, 30, 2'b01, 1'b0);

    // next trigger exactly one period after the first
    trig_pulse("second", t1);
    chk("period", t1 - t0, 200);

    // threshold sweep
    for (int i = 0; i < 6; i++) begin
      if (i > 0) trig_pulse($sformatf("sw%0d", sw_w[i]), t1);
      meas($sformatf("sw%0d", sw_w[i]), sw_w[i], sw_w[i], sw_z[i], 1'b0);
    end

    // no echo at all: timeout after 100 wait cycles
    trig_pulse("noecho", t1);
    v0 = vcnt;
    n = 0;
    while (valid !== 1'b1 && n < 300) begin tick(); n++; end
    chk("noecho_latency", n, 100);
    tick(3);
    chk("noecho_valid_pulses", vcnt - v0, 1);
    chk("noecho_timeout", tmo, 1);
    chk("noecho_zone", zone, 3);
    chk("noecho_cycles", ecyc, 0);

    // echo stuck high longer than the timeout
    trig_pulse("stuck", t1);
    meas("stuck", 150, 100, 2'b11, 1'b1);

    // stale echo already high through the trigger, then a real pulse
    echo = 1'b1;
    trig_pulse("stale", t1);
    v0 = vcnt;
    tick(20);
    echo = 1'b0;
    tick(10);
    echo = 1'b1;
    tick(25);
    echo = 1'b0;
    wait_valid("stale", v0);
    chk("stale_cycles", ecyc, 25);
    chk("stale_zone", zone, 1);
    chk("stale_timeout", tmo, 0);

    // reset in the middle of a measurement
    trig_pulse("rstmid", t1);
    v0 = vcnt;
    tick(10);
    echo = 1'b1;
    tick(20);
    rst = 1'b1;
    echo = 1'b0;
    tick(1);
    chk("rstmid_trig", trig, 0);
    chk("rstmid_zone", zone, 0);
    chk("rstmid_cycles", ecyc, 0);
    chk("rstmid_valid", valid, 0);
    chk("rstmid_timeout", tmo, 0);
    rst = 1'b0;
    tick(1);
    chk("rstmid_trig_first_edge", trig, 1);
    trig_pulse("rstmid_fresh", t1);
    chk("rstmid_no_valid", vcnt - v0, 0);

    // sub-cycle glitch between edges is never sampled -> plain timeout
    v0 = vcnt;
    #1 echo = 1'b1;
    #3 echo = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 300) begin tick(); n++; end
    chk("glitch_latency", n, 100);
    tick(3);
    chk("glitch_valid_pulses", vcnt - v0, 1);
    chk("glitch_timeout", tmo, 1);
    chk("glitch_zone", zone, 3);
    chk("glitch_cycles", ecyc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Generates the ultrasonic sensor trigger pulse and measures the returned echo pulse width in clock cycles.
- Classifies the width into the 2-bit obstacle zone code consumed by the motor mux select.
- Runs free, repeating measurements at a fixed period. Sits between the sensor pins and the motor driver's zone input.

Parameters:
- TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
- PERIOD_CYCLES, 3000000, minimum trigger-start to trigger-start spacing (60 ms)
- TIMEOUT_CYCLES, 1500000, maximum echo wait and echo width (30 ms)
- NEAR_TH, 58000, echo width below this gives zone 2'b00 (about 20 cm)
- MID_TH, 145000, echo width below this gives zone 2'b01 (about 50 cm)
- FAR_TH, 290000, echo width below this gives zone 2'b10 (about 1 m)
- CNT_W, 22, width of all counters and echo_cycles

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- echo  input  1  asynchronous sensor echo pin
- inputTrigger  output  1  sensor trigger pin
- zone  output  2  00 = stop, 01 = near, 10 = mid, 11 = far or no echo
- echo_cycles  output  CNT_W  width of the last measured echo, saturated at TIMEOUT_CYCLES
- valid  output  1  one-cycle pulse when zone and echo_cycles update
- timeout  output  1  last measurement timed out; updated together with zone

Behaviour:
- Reset values: inputTrigger=0, zone=2'b00 (stop is the safe default), echo_cycles=0, valid=0, timeout=0. State=TRIG, all counters 0, synchronizer flops 0.
- Echo synchronization: echo passes through 2 flops to give echo_s. Only echo_s is used internally, so there are 2 cycles of input latency.
- Period counter: cleared on entry to TRIG, increments every cycle, saturates at PERIOD_CYCLES-1.
- TRIG: inputTrigger=1 for exactly TRIG_CYCLES cycles; the first high cycle is the first edge after rst falls. Then go to ARM. echo_s is ignored in TRIG.
- ARM: waits for echo_s low; a stale high echo does not count as an edge. When echo_s is low, go to WAIT_RISE.
- WAIT_RISE:
  - The wait counter counts cycles spent in ARM plus WAIT_RISE.
  - On the first echo_s=1 sample, go to MEASURE with the width counter set to 1.
  - If the wait counter reaches TIMEOUT_CYCLES first, go to DONE with timeout set.
- MEASURE:
  - Each cycle with echo_s=1 increments the width counter.
  - On the first echo_s=0 sample, go to DONE.
  - If the width counter reaches TIMEOUT_CYCLES, go to DONE with timeout set; width is held at TIMEOUT_CYCLES.
- DONE (exactly 1 cycle) registers all results; the new values are visible the following cycle together with valid=1 for one cycle:
  - echo_cycles = width (0 on a no-rise timeout).
  - timeout flag.
  - zone: timeout gives 11; else width<NEAR_TH gives 00, <MID_TH gives 01, <FAR_TH gives 10, else 11.
  - Boundaries: width==NEAR_TH gives 01, width==FAR_TH gives 11.
- IDLE: wait until the period counter equals PERIOD_CYCLES-1, then go to TRIG.
  - If that point already passed during the measurement, DONE goes directly to TRIG.
  - The next trigger therefore starts at max(period expiry, DONE+1).
- Outputs zone, echo_cycles and timeout hold their values between valid pulses.
- rst mid-operation: on the next edge all outputs and state return to their reset values. The trigger drops immediately and any partial measurement is discarded, with no valid pulse.
- Arithmetic: all counters unsigned CNT_W bits and never wrap. Legal parameters satisfy TIMEOUT_CYCLES < 2^CNT_W and NEAR_TH < MID_TH < FAR_TH <= TIMEOUT_CYCLES.

Test Plan (bench parameters: TRIG_CYCLES=4, PERIOD_CYCLES=200, TIMEOUT_CYCLES=100, NEAR_TH=20, MID_TH=40, FAR_TH=80):
- Release rst -> inputTrigger high exactly 4 cycles starting 1 edge after release; zone=00, valid=0 before the first result.
- Echo high 30 cycles, 10 cycles after trigger falls -> echo_cycles=30, zone=01, timeout=0, single valid pulse. Next trigger rises 200 cycles after the previous trigger start.
- Sweep echo widths 19, 20, 39, 40, 79, 80 -> zones 00, 01, 01, 10, 10, 11 respectively.
- No echo -> valid with timeout=1, zone=11, echo_cycles=0, 100 wait cycles after trigger falls. Echo stuck high 150 cycles -> timeout=1, echo_cycles=100, zone=11.
- Echo already high when trigger ends, then falls, then a 25-cycle pulse -> the stale pulse is ignored; echo_cycles=25, zone=01.
- Assert rst for 1 cycle in mid-MEASURE -> outputs return to reset values, no valid pulse, fresh 4-cycle trigger after release. An echo glitch shorter than 1 clk never sampled -> no effect.
